weight_bram_ctrl: RTL and testbench

- Sequencer for the banked weight buffer (BAND_WIDTH single-write, per-lane-read BRAM banks).
- LOAD phase: accepts a weight byte stream and produces the single write port (wea/addra/dia), filling banks row-major.
- READ phase: produces per-lane enb/addrb with a one-cycle diagonal skew per lane, feeding a systolic array column-by-column.
- Sits between the weight DMA stream and the weight buffer; the top-level MMU controller drives it.

---
 rtl/weight_ctrl_pkg.sv | 20 ++
 rtl/weight_rd_skew.sv | 39 +++
 rtl/weight_bram_ctrl.sv | 151 +++++++++++++++
 tb/tb_weight_bram_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_ctrl_pkg.sv
// Shared constants, derived widths and FSM state type for the weight buffer sequencer.
package weight_ctrl_pkg;

    localparam int unsigned SRAM_DEPTH = 50;
    localparam int unsigned BAND_WIDTH = 16;
    localparam int unsigned DATA_WIDTH = 8;

    localparam int unsigned ROW_W   = $clog2(SRAM_DEPTH);
    localparam int unsigned BANK_W  = $clog2(BAND_WIDTH);
    localparam int unsigned T_W     = $clog2(SRAM_DEPTH + BAND_WIDTH);
    localparam int unsigned DEPTH_W = $clog2(SRAM_DEPTH + 1);
    localparam int unsigned ADDRA_W = BANK_W + ROW_W;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ
    } ctrl_state_e;

endpackage

// File: rtl/weight_rd_skew.sv
// Registered per-lane read enable/address generator with one-cycle diagonal skew per lane.
module weight_rd_skew
    import weight_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic [T_W-1:0]     t,
    input  logic [DEPTH_W-1:0] depth,
    output logic               enb   [BAND_WIDTH],
    output logic [ROW_W-1:0]   addrb [BAND_WIDTH]
);

    logic             en_c   [BAND_WIDTH];
    logic [ROW_W-1:0] addr_c [BAND_WIDTH];

    // Lane i sees row t-i while 0 <= t-i < depth; difference kept at full width before truncation.
    for (genvar i = 0; i < BAND_WIDTH; i++) begin : g_lane
        logic [T_W-1:0] diff;
        assign diff      = t - T_W'(i);
        assign en_c[i]   = run && (t >= T_W'(i)) && (diff < T_W'(depth));
        assign addr_c[i] = en_c[i] ? diff[ROW_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BAND_WIDTH; i++) begin
                enb[i]   <= 1'b0;
                addrb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < BAND_WIDTH; i++) begin
                enb[i]   <= en_c[i];
                addrb[i] <= addr_c[i];
            end
        end
    end

endmodule

// File: rtl/weight_bram_ctrl.sv
// Banked weight buffer sequencer: row-major LOAD writes and skewed per-lane READ addressing.
module weight_bram_ctrl
    import weight_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DEPTH_W-1:0]    cfg_depth,
    input  logic                  load_start,
    input  logic                  rd_start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  wea,
    output logic [ADDRA_W-1:0]    addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic                  enb   [BAND_WIDTH],
    output logic [ROW_W-1:0]      addrb [BAND_WIDTH],
    output logic                  busy,
    output logic                  load_done,
    output logic                  rd_done,
    output logic                  cfg_err
);

    ctrl_state_e           state, state_nxt;
    logic [DEPTH_W-1:0]    d, d_nxt;
    logic [BANK_W-1:0]     b, b_nxt;
    logic [ROW_W-1:0]      r, r_nxt;
    logic [T_W-1:0]        t, t_nxt;
    logic                  wea_nxt, load_done_nxt, rd_done_nxt, cfg_err_nxt;
    logic [ADDRA_W-1:0]    addra_nxt;
    logic [DATA_WIDTH-1:0] dia_nxt;
    logic                  rd_run_c;
    logic [T_W-1:0]        rd_t_c;
    logic [DEPTH_W-1:0]    rd_depth_c;
    logic                  depth_ok_c;

    assign depth_ok_c = (cfg_depth != '0) && (cfg_depth <= DEPTH_W'(SRAM_DEPTH));
    assign s_ready    = (state == LOAD);
    assign busy       = (state != IDLE);

    // Next state, counters and registered-output values.
    always_comb begin
        state_nxt     = state;
        d_nxt         = d;
        b_nxt         = b;
        r_nxt         = r;
        t_nxt         = t;
        wea_nxt       = 1'b0;
        addra_nxt     = addra;
        dia_nxt       = dia;
        load_done_nxt = 1'b0;
        rd_done_nxt   = 1'b0;
        cfg_err_nxt   = 1'b0;
        rd_run_c      = 1'b0;
        rd_t_c        = '0;
        rd_depth_c    = d;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    if (depth_ok_c) begin
                        state_nxt = LOAD;
                        d_nxt     = cfg_depth;
                        b_nxt     = '0;
                        r_nxt     = '0;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end else if (rd_start) begin
                    if (depth_ok_c) begin
                        state_nxt  = READ;
                        d_nxt      = cfg_depth;
                        t_nxt      = '0;
                        rd_run_c   = 1'b1;
                        rd_depth_c = cfg_depth;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_valid) begin
                    wea_nxt   = 1'b1;
                    addra_nxt = {b, r};
                    dia_nxt   = s_data;
                    if (b == BANK_W'(BAND_WIDTH - 1)) begin
                        b_nxt = '0;
                        if (r == ROW_W'(d - DEPTH_W'(1))) begin
                            state_nxt     = IDLE;
                            load_done_nxt = 1'b1;
                        end else begin
                            r_nxt = r + ROW_W'(1);
                        end
                    end else begin
                        b_nxt = b + BANK_W'(1);
                    end
                end
            end
            READ: begin
                if (t == T_W'(d) + T_W'(BAND_WIDTH - 2)) begin
                    state_nxt   = IDLE;
                    rd_done_nxt = 1'b1;
                end else begin
                    t_nxt    = t + T_W'(1);
                    rd_run_c = 1'b1;
                    rd_t_c   = t + T_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            d         <= '0;
            b         <= '0;
            r         <= '0;
            t         <= '0;
            wea       <= 1'b0;
            addra     <= '0;
            dia       <= '0;
            load_done <= 1'b0;
            rd_done   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            d         <= d_nxt;
            b         <= b_nxt;
            r         <= r_nxt;
            t         <= t_nxt;
            wea       <= wea_nxt;
            addra     <= addra_nxt;
            dia       <= dia_nxt;
            load_done <= load_done_nxt;
            rd_done   <= rd_done_nxt;
            cfg_err   <= cfg_err_nxt;
        end
    end

    // Skew generator registers the lane outputs for the t value shown next cycle.
    weight_rd_skew u_rd_skew (
        .clk   (clk),
        .rstn  (rstn),
        .run   (rd_run_c),
        .t     (rd_t_c),
        .depth (rd_depth_c),
        .enb   (enb),
        .addrb (addrb)
    );

endmodule

// File: tb/tb_weight_bram_ctrl.sv
// Directed self-checking bench for weight_bram_ctrl: load ordering, skewed reads, start arbitration, errors, reset abort.
module tb_weight_bram_ctrl;

    logic       clk;
    logic       rstn;
    logic [5:0] cfg_depth;
    logic       load_start;
    logic       rd_start;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       wea;
    logic [9:0] addra;
    logic [7:0] dia;
    logic       enb   [16];
    logic [5:0] addrb [16];
    logic       busy;
    logic       load_done;
    logic       rd_done;
    logic       cfg_err;

    int total = 0;
    int bad   = 0;

    weight_bram_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_depth  (cfg_depth),
        .load_start (load_start),
        .rd_start   (rd_start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .wea        (wea),
        .addra      (addra),
        .dia        (dia),
        .enb        (enb),
        .addrb      (addrb),
        .busy       (busy),
        .load_done  (load_done),
        .rd_done    (rd_done),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_en();
        int n = 0;
        for (int i = 0; i < 16; i++) n += (enb[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    function automatic int lane_en(input int tt, input int lane, input int dd);
        return (tt >= lane && tt - lane < dd) ? 1 : 0;
    endfunction

    initial begin
        int n;
        int wcount;
        int errs;
        rstn = 1'b0; cfg_depth = '0; load_start = 1'b0; rd_start = 1'b0;
        s_valid = 1'b0; s_data = '0;
        #12;
        check("rst_wea", 32'(wea), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_enb", 32'(n_en()), 0);
        check("rst_addrb15", 32'(addrb[15]), 0);
        check("rst_addra", 32'(addra), 0);
        check("rst_flags", 32'({load_done, rd_done, cfg_err}), 0);
        rstn = 1'b1;
        tick();

        // Load D=2 with continuous valid
        cfg_depth = 6'd2; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("t1_busy", 32'(busy), 1);
        check("t1_ready", 32'(s_ready), 1);
        s_valid = 1'b1; s_data = 8'd0;
        for (int k = 0; k < 32; k++) begin
            tick();
            check($sformatf("t1_wea%0d", k), 32'(wea), 1);
            check($sformatf("t1_addra%0d", k), 32'(addra), 32'((k % 16) * 64 + k / 16));
            check($sformatf("t1_dia%0d", k), 32'(dia), 32'(k));
            check($sformatf("t1_done%0d", k), 32'(load_done), (k == 31) ? 1 : 0);
            check($sformatf("t1_ready%0d", k), 32'(s_ready), (k == 31) ? 0 : 1);
            s_data = 8'(k + 1);
        end
        s_valid = 1'b0;
        tick();
        check("t1_wea_after", 32'(wea), 0);
        check("t1_done_after", 32'(load_done), 0);
        check("t1_busy_after", 32'(busy), 0);

        // Load D=2 with valid toggling
        cfg_depth = 6'd2; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0; wcount = 0;
        for (int c = 0; c < 64; c++) begin
            s_valid = (c % 2 == 0);
            s_data  = 8'(8'h40 + n);
            tick();
            if (wea === 1'b1) wcount++;
            if (c % 2 == 0) begin
                check($sformatf("t2_wea%0d", c), 32'(wea), 1);
                check($sformatf("t2_addra%0d", c), 32'(addra), 32'((n % 16) * 64 + n / 16));
                check($sformatf("t2_dia%0d", c), 32'(dia), 32'(8'h40 + n));
                check($sformatf("t2_done%0d", c), 32'(load_done), (n == 31) ? 1 : 0);
                n++;
            end else begin
                check($sformatf("t2_idle%0d", c), 32'(wea), 0);
            end
        end
        s_valid = 1'b0;
        check("t2_writes", 32'(wcount), 32);
        check("t2_busy", 32'(busy), 0);
        tick();

        // Read D=3: 18 output cycles
        cfg_depth = 6'd3; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int tt = 0; tt < 18; tt++) begin
            check($sformatf("t3_enb0_%0d", tt), 32'(enb[0]), 32'(lane_en(tt, 0, 3)));
            check($sformatf("t3_a0_%0d", tt), 32'(addrb[0]), lane_en(tt, 0, 3) != 0 ? 32'(tt) : 0);
            check($sformatf("t3_enb7_%0d", tt), 32'(enb[7]), 32'(lane_en(tt, 7, 3)));
            check($sformatf("t3_a7_%0d", tt), 32'(addrb[7]), lane_en(tt, 7, 3) != 0 ? 32'(tt - 7) : 0);
            check($sformatf("t3_enb15_%0d", tt), 32'(enb[15]), 32'(lane_en(tt, 15, 3)));
            check($sformatf("t3_a15_%0d", tt), 32'(addrb[15]), lane_en(tt, 15, 3) != 0 ? 32'(tt - 15) : 0);
            check($sformatf("t3_busy%0d", tt), 32'(busy), 1);
            check($sformatf("t3_flags%0d", tt), 32'({wea, rd_done}), 0);
            tick();
        end
        check("t3_rd_done", 32'(rd_done), 1);
        check("t3_enb_off", 32'(n_en()), 0);
        check("t3_a15_off", 32'(addrb[15]), 0);
        check("t3_busy_off", 32'(busy), 0);
        tick();
        check("t3_rd_done_clr", 32'(rd_done), 0);

        // Both starts together, D=1: LOAD wins
        cfg_depth = 6'd1; load_start = 1'b1; rd_start = 1'b1;
        tick();
        load_start = 1'b0; rd_start = 1'b0;
        check("t4_ready", 32'(s_ready), 1);
        s_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_data = 8'(k + 8'h80);
            tick();
            check($sformatf("t4_enb%0d", k), 32'(n_en()), 0);
            check($sformatf("t4_addra%0d", k), 32'(addra), 32'(k * 64));
            check($sformatf("t4_done%0d", k), 32'(load_done), (k == 15) ? 1 : 0);
        end
        s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_quiet%0d", k), 32'({rd_done, busy, wea}), 0);
            check($sformatf("t4_enb_q%0d", k), 32'(n_en()), 0);
        end

        // Illegal depths
        errs = 0;
        cfg_depth = 6'd0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        errs += (cfg_err === 1'b1) ? 1 : 0;
        check("t5_err0", 32'(cfg_err), 1);
        check("t5_busy0", 32'(busy), 0);
        tick();
        check("t5_err0_clr", 32'(cfg_err), 0);
        cfg_depth = 6'd51; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        errs += (cfg_err === 1'b1) ? 1 : 0;
        check("t5_err51", 32'(cfg_err), 1);
        check("t5_busy51", 32'(busy), 0);
        tick();
        check("t5_quiet", 32'({cfg_err, busy, wea}), 0);
        check("t5_enb", 32'(n_en()), 0);
        check("t5_pulses", 32'(errs), 2);

        // Reset during READ at t=5, D=50
        cfg_depth = 6'd50; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("t6_pre_enb5", 32'(enb[5]), 1);
        check("t6_pre_a0", 32'(addrb[0]), 5);
        check("t6_pre_enb", 32'(n_en()), 6);
        rstn = 1'b0;
        #1;
        check("t6_rst_enb", 32'(n_en()), 0);
        check("t6_rst_a0", 32'(addrb[0]), 0);
        check("t6_rst_busy", 32'(busy), 0);
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_no_done%0d", k), 32'({rd_done, busy}), 0);
        end
        cfg_depth = 6'd50; rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("t6_re_enb0", 32'(enb[0]), 1);
        check("t6_re_a0", 32'(addrb[0]), 0);
        check("t6_re_enb1", 32'(enb[1]), 0);
        tick();
        check("t6_re_a0_1", 32'(addrb[0]), 1);
        check("t6_re_enb1_1", 32'(enb[1]), 1);
        check("t6_re_a1_1", 32'(addrb[1]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
